// File: rtl/dmem_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_lsu_ctrl
// Description : Load/store/AMO sequencer in front of a byte-addressed data
//               memory with registered, sign/zero-extended responses.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_lsu_ctrl #(
    parameter int ADDR_W = 13
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [2:0]        req_op_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [31:0]       rsp_data_o,
    output logic              rsp_err_o,
    output logic              mem_write_o,
    output logic [3:0]        mem_b_sel_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_data_o,
    input  logic [31:0]       mem_data_i
);

    localparam logic [2:0]        c_OP_STORE = 3'b001;
    localparam logic [ADDR_W-1:0] c_ADDR_MAX = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXEC   = 2'd1,
        S_AMO_WR = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t             r_state;
    logic [2:0]         r_op;
    logic [1:0]         r_size;
    logic               r_unsigned;
    logic [31:0]        r_wdata;
    logic               r_rsp_valid;
    logic [31:0]        r_rsp_data;
    logic               r_rsp_err;
    logic               r_mem_write;
    logic [3:0]         r_mem_b_sel;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [31:0]        r_mem_data;

    logic [1:0]         w_nbytes_m1;
    logic [3:0]         w_lanes;
    logic [31:0]        w_wdata_masked;
    logic               w_illegal;
    logic [31:0]        w_load_data;
    logic [31:0]        w_amo_new;

    // Request decode: lanes, masked write data and legality
    always_comb begin
        w_nbytes_m1    = 2'd0;
        w_lanes        = 4'b0000;
        w_wdata_masked = 32'h0;
        case (req_size_i)
            2'b00: begin
                w_nbytes_m1    = 2'd0;
                w_lanes        = 4'b0001;
                w_wdata_masked = {24'h0, req_wdata_i[7:0]};
            end
            2'b01: begin
                w_nbytes_m1    = 2'd1;
                w_lanes        = 4'b0011;
                w_wdata_masked = {16'h0, req_wdata_i[15:0]};
            end
            2'b10: begin
                w_nbytes_m1    = 2'd3;
                w_lanes        = 4'b1111;
                w_wdata_masked = req_wdata_i;
            end
            default: begin
                w_nbytes_m1    = 2'd0;
                w_lanes        = 4'b0000;
                w_wdata_masked = 32'h0;
            end
        endcase
    end

    // Range check written as a compare so no carry bit is needed
    assign w_illegal = (req_op_i[2:1] == 2'b01)
                     | (req_size_i == 2'b11)
                     | (req_addr_i > (c_ADDR_MAX - ADDR_W'(w_nbytes_m1)))
                     | (req_op_i[2] & ((req_size_i != 2'b10) | (req_addr_i[1:0] != 2'b00)));

    always_comb begin
        w_load_data = mem_data_i;
        case (r_size)
            2'b00:   w_load_data = {{24{~r_unsigned & mem_data_i[7]}},  mem_data_i[7:0]};
            2'b01:   w_load_data = {{16{~r_unsigned & mem_data_i[15]}}, mem_data_i[15:0]};
            default: w_load_data = mem_data_i;
        endcase
    end

    always_comb begin
        w_amo_new = r_wdata;
        case (r_op[1:0])
            2'b00:   w_amo_new = r_wdata;
            2'b01:   w_amo_new = mem_data_i + r_wdata;
            2'b10:   w_amo_new = mem_data_i & r_wdata;
            default: w_amo_new = mem_data_i | r_wdata;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_op        <= 3'b000;
            r_size      <= 2'b00;
            r_unsigned  <= 1'b0;
            r_wdata     <= 32'h0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 32'h0;
            r_rsp_err   <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_b_sel <= 4'b0000;
            r_mem_addr  <= '0;
            r_mem_data  <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        r_op       <= req_op_i;
                        r_size     <= req_size_i;
                        r_unsigned <= req_unsigned_i;
                        r_wdata    <= req_wdata_i;
                        if (w_illegal) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_data  <= 32'h0;
                            r_state     <= S_RESP;
                        end else begin
                            r_mem_write <= (req_op_i == c_OP_STORE);
                            r_mem_b_sel <= w_lanes;
                            r_mem_addr  <= req_addr_i;
                            r_mem_data  <= w_wdata_masked;
                            r_state     <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    if (r_op[2]) begin
                        r_rsp_data  <= mem_data_i;
                        r_mem_write <= 1'b1;
                        r_mem_data  <= w_amo_new;
                        r_state     <= S_AMO_WR;
                    end else begin
                        r_rsp_data  <= (r_op == c_OP_STORE) ? 32'h0 : w_load_data;
                        r_rsp_valid <= 1'b1;
                        r_mem_write <= 1'b0;
                        r_mem_b_sel <= 4'b0000;
                        r_mem_addr  <= '0;
                        r_mem_data  <= 32'h0;
                        r_state     <= S_RESP;
                    end
                end
                S_AMO_WR: begin
                    r_rsp_valid <= 1'b1;
                    r_mem_write <= 1'b0;
                    r_mem_b_sel <= 4'b0000;
                    r_mem_addr  <= '0;
                    r_mem_data  <= 32'h0;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_data  <= 32'h0;
                        r_rsp_err   <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready_o = (r_state == S_IDLE);
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_data_o  = r_rsp_data;
    assign rsp_err_o   = r_rsp_err;
    assign mem_write_o = r_mem_write;
    assign mem_b_sel_o = r_mem_b_sel;
    assign mem_addr_o  = r_mem_addr;
    assign mem_data_o  = r_mem_data;

endmodule
`default_nettype wire

// File: tb/tb_dmem_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_lsu_ctrl
// Description : Directed self-checking bench for dmem_lsu_ctrl with an 8 KiB
//               byte memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_lsu_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [2:0]  req_op_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [12:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_data_o;
    logic        rsp_err_o;
    logic        mem_write_o;
    logic [3:0]  mem_b_sel_o;
    logic [12:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic [7:0] mem [0:8191];

    dmem_lsu_ctrl #(.ADDR_W(13)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_op_i       (req_op_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_data_o     (rsp_data_o),
        .rsp_err_o      (rsp_err_o),
        .mem_write_o    (mem_write_o),
        .mem_b_sel_o    (mem_b_sel_o),
        .mem_addr_o     (mem_addr_o),
        .mem_data_o     (mem_data_o),
        .mem_data_i     (mem_data_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(posedge clk_i) begin
        if (mem_write_o) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_b_sel_o[i]) mem[mem_addr_o + 13'(i)] <= mem_data_o[8*i +: 8];
            end
        end
    end

    always_comb begin
        mem_data_i = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (mem_b_sel_o[i]) mem_data_i[8*i +: 8] = mem[mem_addr_o + 13'(i)];
        end
    end

    // Issue one request; lat counts edges from accept to rsp_valid (99 = timeout)
    task automatic run_req(input logic [2:0] op, input logic [1:0] size, input logic uns,
                           input logic [12:0] addr, input logic [31:0] wdata, input bit consume,
                           output logic [31:0] d, output logic e, output int lat,
                           output int wcnt, output logic [3:0] wsel, output int acc);
        bit rdy;
        int tries;
        req_op_i = op; req_size_i = size; req_unsigned_i = uns;
        req_addr_i = addr; req_wdata_i = wdata; req_valid_i = 1'b1;
        lat = 99; wcnt = 0; wsel = 4'b0; d = 32'h0; e = 1'b0; acc = 0; tries = 0;
        do begin
            rdy = req_ready_o;
            @(posedge clk_i);
            tries++;
            if (!rdy) #1;
        end while (!rdy && tries < 20);
        #1;
        req_valid_i = 1'b0;
        if (!rdy) return;
        acc = cyc;
        lat = 1;
        while (!rsp_valid_o && lat < 20) begin
            if (mem_write_o) begin wcnt++; wsel = mem_b_sel_o; end
            @(posedge clk_i);
            lat++;
            #1;
        end
        if (!rsp_valid_o) lat = 99;
        d = rsp_data_o;
        e = rsp_err_o;
        if (consume) begin @(posedge clk_i); #1; end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; req_valid_i = 1'b0; rsp_ready_i = 1'b1;
        req_op_i = 3'b0; req_size_i = 2'b0; req_unsigned_i = 1'b0;
        req_addr_i = 13'h0; req_wdata_i = 32'h0;
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(posedge clk_i); #1;
        vectors++; if (req_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset req_ready: got %b want 1", req_ready_o); end
        vectors++; if (rsp_valid_o !== 1'b0 || rsp_err_o !== 1'b0 || rsp_data_o !== 32'h0) begin
            miscompares++; $display("FAIL reset rsp: got v=%b e=%b d=%h want 0/0/0", rsp_valid_o, rsp_err_o, rsp_data_o); end
        vectors++; if ({mem_write_o, mem_b_sel_o, mem_addr_o, mem_data_o} !== '0) begin
            miscompares++; $display("FAIL reset mem: got w=%b s=%b a=%h d=%h want all 0", mem_write_o, mem_b_sel_o, mem_addr_o, mem_data_o); end
    endtask

    task automatic test_store_load();
        logic [31:0] d; logic e; int lat, wc, acc; logic [3:0] ws;
        run_req(3'b001, 2'b10, 1'b0, 13'h0010, 32'hDEADBEEF, 1'b1, d, e, lat, wc, ws, acc);
        vectors++; if (lat !== 2 || wc !== 1 || ws !== 4'b1111 || d !== 32'h0 || e !== 1'b0) begin
            miscompares++; $display("FAIL st_word: got lat=%0d wr=%0d sel=%b d=%h e=%b want 2/1/1111/0/0", lat, wc, ws, d, e); end
        run_req(3'b000, 2'b00, 1'b0, 13'h0011, 32'h0, 1'b1, d, e, lat, wc, ws, acc);
        vectors++; if (d !== 32'hFFFFFFBE || e !== 1'b0 || lat !== 2 || wc !== 0) begin
            miscompares++; $display("FAIL ld_byte_s: got d=%h e=%b lat=%0d wr=%0d want FFFFFFBE/0/2/0", d, e, lat, wc); end
        run_req(3'b000, 2'b01, 1'b1, 13'h0012, 32'h0, 1'b1, d, e, lat, wc, ws, acc);
        vectors++; if (d !== 32'h0000DEAD || e !== 1'b0) begin
            miscompares++; $display("FAIL ld_half_u: got d=%h e=%b want 0000DEAD/0", d, e); end
        run_req(3'b000, 2'b01, 1'b0, 13'h0010, 32'h0, 1'b1, d, e, lat, wc, ws, acc);
        vectors++; if (d !== 32'hFFFFBEEF) begin
            miscompares++; $display("FAIL ld_half_s: got %h want FFFFBEEF", d); end
        run_req(3'b000, 2'b00, 1'b1, 13'h0013, 32'h0, 1'b1, d, e, lat, wc, ws, acc);
        vectors++; if (d !== 32'h000000DE) begin
            miscompares++; $display("FAIL ld_byte_u: got %h want 000000DE", d); end
    endtask

    task automatic test_byte_store();
        logic [31:0] d; logic e; int lat, wc, acc; logic [3:0] ws;
        run_req(3'b001, 2'b10, 1'b0, 13'h0000, 32'h11223344, 1'b1, d, e, lat, wc, ws, acc);
        run_req(3'b001, 2'b00, 1'b0, 13'h0003, 32'hFFFFFFA5, 1'b1, d, e, lat, wc, ws, acc);
        vectors++; if (ws !== 4'b0001 || wc !== 1) begin
            miscompares++; $display("FAIL st_byte sel: got sel=%b wr=%0d want 0001/1", ws, wc); end
        run_req(3'b000, 2'b10, 1'b0, 13'h0000, 32'h0, 1'b1, d, e, lat, wc, ws, acc);
        vectors++; if (d !== 32'hA5223344) begin
            miscompares++; $display("FAIL st_byte readback: got %h want A5223344", d); end
    endtask

    task automatic test_amo();
        logic [31:0] d; logic e; int lat, wc, acc; logic [3:0] ws;
        run_req(3'b001, 2'b10, 1'b0, 13'h0100, 32'hFFFFFFFF, 1'b1, d, e, lat, wc, ws, acc);
        run_req(3'b101, 2'b10, 1'b0, 13'h0100, 32'h00000001, 1'b1, d, e, lat, wc, ws, acc);
        vectors++; if (d !== 32'hFFFFFFFF || e !== 1'b0) begin
            miscompares++; $display("FAIL amoadd old: got d=%h e=%b want FFFFFFFF/0", d, e); end
        vectors++; if (lat !== 3 || wc !== 1) begin
            miscompares++; $display("FAIL amoadd timing: got lat=%0d wr=%0d want 3/1", lat, wc); end
        run_req(3'b000, 2'b10, 1'b0, 13'h0100, 32'h0, 1'b1, d, e, lat, wc, ws, acc);
        vectors++; if (d !== 32'h00000000) begin
            miscompares++; $display("FAIL amoadd new: got %h want 00000000", d); end
        run_req(3'b001, 2'b10, 1'b0, 13'h0104, 32'h0F0F0000, 1'b1, d, e, lat, wc, ws, acc);
        run_req(3'b111, 2'b10, 1'b0, 13'h0104, 32'h000000F0, 1'b1, d, e, lat, wc, ws, acc);
        run_req(3'b110, 2'b10, 1'b0, 13'h0104, 32'h0F0000FF, 1'b1, d, e, lat, wc, ws, acc);
        vectors++; if (d !== 32'h0F0F00F0) begin
            miscompares++; $display("FAIL amoor/amoand old: got %h want 0F0F00F0", d); end
        run_req(3'b100, 2'b10, 1'b0, 13'h0104, 32'hCAFEF00D, 1'b1, d, e, lat, wc, ws, acc);
        vectors++; if (d !== 32'h0F0000F0) begin
            miscompares++; $display("FAIL amoand result: got %h want 0F0000F0", d); end
        run_req(3'b000, 2'b10, 1'b0, 13'h0104, 32'h0, 1'b1, d, e, lat, wc, ws, acc);
        vectors++; if (d !== 32'hCAFEF00D) begin
            miscompares++; $display("FAIL amoswap result: got %h want CAFEF00D", d); end
    endtask

    task automatic test_errors();
        logic [31:0] d; logic e; int lat, wc, acc; logic [3:0] ws;
        logic [2:0]  ops   [4] = '{3'b000, 3'b100, 3'b010, 3'b000};
        logic [1:0]  sizes [4] = '{2'b10, 2'b10, 2'b10, 2'b11};
        logic [12:0] addrs [4] = '{13'h1FFE, 13'h0102, 13'h0000, 13'h0000};
        for (int k = 0; k < 4; k++) begin
            run_req(ops[k], sizes[k], 1'b0, addrs[k], 32'h12345678, 1'b1, d, e, lat, wc, ws, acc);
            vectors++; if (e !== 1'b1 || d !== 32'h0 || wc !== 0 || lat !== 1) begin
                miscompares++; $display("FAIL err case %0d: got e=%b d=%h wr=%0d lat=%0d want 1/0/0/1", k, e, d, wc, lat); end
        end
        run_req(3'b000, 2'b00, 1'b0, 13'h1FFF, 32'h0, 1'b1, d, e, lat, wc, ws, acc);
        vectors++; if (e !== 1'b0 || lat !== 2) begin
            miscompares++; $display("FAIL last byte legal: got e=%b lat=%0d want 0/2", e, lat); end
    endtask

    task automatic test_backpressure();
        logic [31:0] d; logic e; int lat, wc, acc; logic [3:0] ws;
        rsp_ready_i = 1'b0;
        run_req(3'b000, 2'b10, 1'b0, 13'h0010, 32'h0, 1'b0, d, e, lat, wc, ws, acc);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk_i); #1;
            vectors++; if (rsp_valid_o !== 1'b1 || rsp_data_o !== 32'hDEADBEEF || req_ready_o !== 1'b0) begin
                miscompares++; $display("FAIL stall rsp cyc %0d: got v=%b d=%h rdy=%b want 1/DEADBEEF/0", k, rsp_valid_o, rsp_data_o, req_ready_o); end
            vectors++; if (mem_write_o !== 1'b0 || mem_b_sel_o !== 4'b0 || mem_addr_o !== 13'h0) begin
                miscompares++; $display("FAIL stall mem cyc %0d: got w=%b s=%b a=%h want idle", k, mem_write_o, mem_b_sel_o, mem_addr_o); end
        end
        rsp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        vectors++; if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
            miscompares++; $display("FAIL stall release: got v=%b rdy=%b want 0/1", rsp_valid_o, req_ready_o); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d; logic e; int lat, wc, a0, a1, a2, a3; logic [3:0] ws;
        run_req(3'b000, 2'b10, 1'b0, 13'h0000, 32'h0, 1'b1, d, e, lat, wc, ws, a0);
        run_req(3'b001, 2'b01, 1'b0, 13'h0020, 32'h0000BEEF, 1'b1, d, e, lat, wc, ws, a1);
        run_req(3'b101, 2'b10, 1'b0, 13'h0100, 32'h5, 1'b1, d, e, lat, wc, ws, a2);
        run_req(3'b011, 2'b10, 1'b0, 13'h0000, 32'h0, 1'b1, d, e, lat, wc, ws, a3);
        vectors++; if (a1 - a0 !== 3) begin miscompares++; $display("FAIL b2b load: got %0d want 3", a1 - a0); end
        vectors++; if (a2 - a1 !== 3) begin miscompares++; $display("FAIL b2b store: got %0d want 3", a2 - a1); end
        vectors++; if (a3 - a2 !== 4) begin miscompares++; $display("FAIL b2b amo: got %0d want 4", a3 - a2); end
        run_req(3'b000, 2'b10, 1'b0, 13'h0000, 32'h0, 1'b1, d, e, lat, wc, ws, a0);
        vectors++; if (a0 - a3 !== 2) begin miscompares++; $display("FAIL b2b err: got %0d want 2", a0 - a3); end
    endtask

    task automatic test_reset_during_amo();
        logic [31:0] d; logic e; int lat, wc, acc; logic [3:0] ws;
        run_req(3'b001, 2'b10, 1'b0, 13'h0200, 32'h00000077, 1'b1, d, e, lat, wc, ws, acc);
        req_op_i = 3'b100; req_size_i = 2'b10; req_addr_i = 13'h0200;
        req_wdata_i = 32'h00000055; req_valid_i = 1'b1;
        @(posedge clk_i); #1 req_valid_i = 1'b0;
        @(posedge clk_i); #1;
        vectors++; if (mem_write_o !== 1'b1 || mem_data_o !== 32'h55) begin
            miscompares++; $display("FAIL amo_wr entry: got w=%b d=%h want 1/00000055", mem_write_o, mem_data_o); end
        rst_ni = 1'b0;
        #1;
        vectors++; if (mem_write_o !== 1'b0 || mem_b_sel_o !== 4'b0 || mem_addr_o !== 13'h0 || mem_data_o !== 32'h0) begin
            miscompares++; $display("FAIL async rst mem: got w=%b s=%b a=%h d=%h want 0", mem_write_o, mem_b_sel_o, mem_addr_o, mem_data_o); end
        vectors++; if (rsp_valid_o !== 1'b0 || rsp_data_o !== 32'h0 || rsp_err_o !== 1'b0 || req_ready_o !== 1'b1) begin
            miscompares++; $display("FAIL async rst rsp: got v=%b d=%h e=%b rdy=%b want 0/0/0/1", rsp_valid_o, rsp_data_o, rsp_err_o, req_ready_o); end
        @(posedge clk_i); #1 rst_ni = 1'b1;
        vectors++; if ({mem[13'h203], mem[13'h202], mem[13'h201], mem[13'h200]} !== 32'h00000077) begin
            miscompares++; $display("FAIL mem after rst: got %h want 00000077", {mem[13'h203], mem[13'h202], mem[13'h201], mem[13'h200]}); end
        run_req(3'b000, 2'b10, 1'b0, 13'h0200, 32'h0, 1'b1, d, e, lat, wc, ws, acc);
        vectors++; if (d !== 32'h00000077 || lat !== 2) begin
            miscompares++; $display("FAIL load after rst: got d=%h lat=%0d want 00000077/2", d, lat); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_store();
        test_amo();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_during_amo();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
